counter_checker: RTL and testbench

COUNTER_CHECKER -- requirements
Module: counter_checker

---
 rtl/counter_pkg.sv | 15 +
 rtl/sat_counter.sv | 19 +
 rtl/counter_checker.sv | 115 +++++++++++
 tb/tb_counter_checker.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter stream checker: state encoding and defaults.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_LOCK_CNT = 4;
  localparam int RUN_W        = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Monitors a free-running counter stream, locks onto a clean +1 sequence and flags breaks.
// Optional wrap detection is compiled in when COUNTER_CHECKER_WRAP_EN is defined.
//
//   state  | meaning
//   IDLE   | first sample after reset, captures prev
//   SYNC   | counting consecutive +1 steps towards lock
//   LOCKED | stream tracked; a mismatch is an error
//   ERROR  | one-cycle recovery after a break, then SYNC
module counter_checker
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             dut_reset,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap_pulse
);

  state_t             state, state_next;
  logic [WIDTH-1:0]   prev, prev_next, prev_inc;
  logic [RUN_W-1:0]   run, run_next, run_inc;
  logic               match;
  logic               err_next;
  logic               wrap_next;

  assign prev_inc = prev + WIDTH'(1);
  assign run_inc  = run + RUN_W'(1);
  assign match    = (value == prev_inc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prev      <= '0;
      run       <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      prev      <= prev_next;
      run       <= run_next;
      err_pulse <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    prev_next  = value;
    run_next   = run;
    err_next   = 1'b0;
    wrap_next  = 1'b0;
    if (dut_reset) begin
      // all-ones makes the first post-reset sample of 0 count as a match
      state_next = SYNC;
      run_next   = '0;
      prev_next  = {WIDTH{1'b1}};
    end else begin
      case (state)
        IDLE: begin
          run_next   = '0;
          state_next = SYNC;
        end
        SYNC: begin
          if (match) begin
            run_next = run_inc;
            if (run_inc == RUN_W'(LOCK_CNT)) state_next = LOCKED;
          end else begin
            run_next = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            state_next = ERROR;
            err_next   = 1'b1;
          end else if ((prev == {WIDTH{1'b1}}) && (value == '0)) begin
            wrap_next  = 1'b1;
          end
        end
        ERROR: begin
          run_next   = '0;
          state_next = SYNC;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign locked = (state == LOCKED);

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_next),
    .count (err_count)
  );

`ifdef COUNTER_CHECKER_WRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wrap_pulse <= 1'b0;
    else        wrap_pulse <= wrap_next;
  end
`else
  assign wrap_pulse = 1'b0;
  logic unused_wrap;
  assign unused_wrap = wrap_next;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: a default instance and an ERR_W=2 instance share stimulus.
module tb_counter_checker;

  logic       clk;
  logic       reset;
  logic [7:0] value;
  logic       dut_reset;

  logic       locked, err_pulse, wrap_pulse;
  logic [7:0] err_count;
  logic       locked2, err_pulse2, wrap_pulse2;
  logic [1:0] err_count2;

  typedef struct {
    logic       lck;
    logic       err;
    logic       wrp;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   e_cnt    = 0;

  counter_checker #(.WIDTH(8), .LOCK_CNT(4), .ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dut_reset  (dut_reset),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .wrap_pulse (wrap_pulse)
  );

  counter_checker #(.WIDTH(8), .LOCK_CNT(4), .ERR_W(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dut_reset  (dut_reset),
    .locked     (locked2),
    .err_pulse  (err_pulse2),
    .err_count  (err_count2),
    .wrap_pulse (wrap_pulse2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    logic [7:0] cnt2;
    cnt2 = (e.cnt > 8'd3) ? 8'd3 : e.cnt;
    chk({tag, ".locked"},  {7'd0, locked},     {7'd0, e.lck});
    chk({tag, ".err"},     {7'd0, err_pulse},  {7'd0, e.err});
    chk({tag, ".wrap"},    {7'd0, wrap_pulse}, {7'd0, e.wrp});
    chk({tag, ".cnt"},     err_count,          e.cnt);
    chk({tag, ".locked2"}, {7'd0, locked2},    {7'd0, e.lck});
    chk({tag, ".err2"},    {7'd0, err_pulse2}, {7'd0, e.err});
    chk({tag, ".cnt2"},    {6'd0, err_count2}, cnt2);
  endtask

  // Drive one sample at the negedge, push the expected post-edge outputs, check after the edge.
  task automatic step(input string tag, input logic [7:0] v, input logic dr,
                      input logic el, input logic ee, input logic ew);
    exp_t e;
    value     = v;
    dut_reset = dr;
    if (ee) e_cnt++;
    e.lck = el;
    e.err = ee;
`ifdef COUNTER_CHECKER_WRAP_EN
    e.wrp = ew;
`else
    e.wrp = 1'b0;
`endif
    e.cnt = 8'(e_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    chk_all(tag, sb_q.pop_front());
    @(negedge clk);
  endtask

  task automatic relock_from_idle(input string tag);
    for (int i = 0; i < 4; i++) step(tag, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    step({tag, ".lock"}, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t z;
    z.lck = 1'b0; z.err = 1'b0; z.wrp = 1'b0; z.cnt = 8'd0;
    reset     = 1'b0;
    value     = 8'd0;
    dut_reset = 1'b0;
    #3;
    chk_all("reset", z);

    @(negedge clk);
    reset = 1'b1;
    relock_from_idle("lock0");

    for (int i = 5; i <= 16; i++) step("run", 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    step("break", 8'h13, 1'b0, 1'b0, 1'b1, 1'b0);
    step("err_rec", 8'h14, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 8'h15; i <= 8'h17; i++) step("resync", 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    step("relock", 8'h18, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 8'h19; i <= 8'h37; i++) step("run37", 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("dut_rst", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("post_rst0", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_rst1", 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_rst2", 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_rst3", 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step("post_rst4", 8'd4, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 5; i <= 8'hFD; i++) step("run_up", 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    step("wrap_fe", 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
    step("wrap_ff", 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    step("wrap_00", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    step("wrap_01", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);

    step("break2", 8'h50, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    e_cnt = 0;
    chk_all("async_rst", z);
    @(negedge clk);
    reset = 1'b1;
    relock_from_idle("lock_after_rst");

    for (int k = 0; k < 5; k++) begin
      step("sat_break", 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 8'h81; i <= 8'h84; i++) step("sat_sync", 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      step("sat_lock", 8'h85, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
